cipher_stream_ctrl: RTL and testbench



---
 rtl/cipher_pkg.sv | 13 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/cipher_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_cipher_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and widths for the XOR cipher stream wrapper.
package cipher_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CORE_LAT = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REL
    } ctrl_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a combinational head read and an occupancy count.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= CW'(0);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cipher_stream_ctrl.sv
// Valid/ready byte stream wrapper around the XOR cipher core, one byte in flight.
// Optional CIPHER_KEY_ROLL_EN: active key increments after every completed byte.
module cipher_stream_ctrl
    import cipher_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_we,
    input  logic [BYTE_W-1:0] key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              c_start,
    output logic [BYTE_W-1:0] c_key,
    output logic [BYTE_W-1:0] c_plaintext,
    input  logic              c_done,
    input  logic [BYTE_W-1:0] c_ciphertext,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    ctrl_state_t       state;
    logic [TMR_W-1:0]  timer;
    logic [BYTE_W-1:0] pend_key;
    logic              key_pend;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // Issue only when the previous result has left and the core is back to idle.
    assign pop      = (state == S_IDLE) && !fifo_empty && !out_valid && !c_done;
    assign busy     = (state != S_IDLE) || (fifo_count != CNT_W'(0));

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= TMR_W'(0);
            pend_key    <= BYTE_W'(0);
            key_pend    <= 1'b0;
            c_key       <= BYTE_W'(0);
            c_plaintext <= BYTE_W'(0);
            c_start     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= BYTE_W'(0);
            err         <= 1'b0;
        end else begin
            if (key_we) begin
                pend_key <= key_in;
                key_pend <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (timer != TMR_MAX) begin
                timer <= timer + TMR_W'(1);
            end

            case (state)
                S_IDLE: begin
                    // A key written this very cycle stays pending for the next idle cycle.
                    if (key_pend) begin
                        c_key <= pend_key;
                        if (!key_we) begin
                            key_pend <= 1'b0;
                        end
                    end
                    if (pop) begin
                        c_plaintext <= fifo_rdata;
                        c_start     <= 1'b1;
                        timer       <= TMR_W'(0);
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (c_done) begin
                        out_data  <= c_ciphertext;
                        out_valid <= 1'b1;
                        c_start   <= 1'b0;
                        timer     <= TMR_W'(0);
                        state     <= S_REL;
`ifdef CIPHER_KEY_ROLL_EN
                        c_key     <= c_key + BYTE_W'(1);
`else
                        c_key     <= c_key;
`endif
                    end else if (timer == TMR_MAX) begin
                        err     <= 1'b1;
                        c_start <= 1'b0;
                        timer   <= TMR_W'(0);
                        state   <= S_REL;
                    end
                end
                S_REL: begin
                    if (!c_done) begin
                        timer <= TMR_W'(0);
                        state <= S_IDLE;
                    end else if (timer == TMR_MAX) begin
                        err   <= 1'b1;
                        timer <= TMR_W'(0);
                        state <= S_IDLE;
                    end
                end
                default: begin
                    c_start <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Directed bench for cipher_stream_ctrl with a behavioural XOR core model.
module tb_cipher_stream_ctrl;
    import cipher_pkg::*;

`ifdef CIPHER_KEY_ROLL_EN
    localparam bit ROLL = 1'b1;
`else
    localparam bit ROLL = 1'b0;
`endif
    localparam int TMO = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_we;
    logic [7:0] key_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       c_start;
    logic [7:0] c_key;
    logic [7:0] c_plaintext;
    logic       c_done = 1'b0;
    logic [7:0] c_ciphertext = 8'h00;
    logic       busy;
    logic       err;

    logic       core_stall = 1'b0;
    logic [3:0] ccnt = 4'd0;
    logic       prev_start = 1'b0;
    int         pulses = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0] key;
        logic [7:0] pt;
        logic [7:0] ct;
    } vec_t;

    cipher_stream_ctrl #(.DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_we       (key_we),
        .key_in       (key_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .c_start      (c_start),
        .c_key        (c_key),
        .c_plaintext  (c_plaintext),
        .c_done       (c_done),
        .c_ciphertext (c_ciphertext),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: load cycle, eight process cycles, then done until start falls.
    always @(posedge clk) begin
        if (!c_start) begin
            ccnt   <= 4'd0;
            c_done <= 1'b0;
        end else if (!c_done && !core_stall) begin
            if (ccnt == 4'd9) begin
                c_done       <= 1'b1;
                c_ciphertext <= c_key ^ c_plaintext;
            end else begin
                ccnt <= ccnt + 4'd1;
            end
        end
    end

    always @(posedge clk) begin
        prev_start <= c_start;
        if (c_start && !prev_start) pulses <= pulses + 1;
    end

    function automatic logic [7:0] ek(input logic [7:0] k, input int i);
        return k + (ROLL ? 8'(i) : 8'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic keywr(input logic [7:0] k);
        key_we = 1'b1;
        key_in = k;
        @(negedge clk);
        key_we = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cstart(output int t);
        int w = 0;
        while (!c_start && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("c_start_seen", c_start, 1'b1);
        t = cyc;
    endtask

    // Returns the first valid output byte, then moves one cycle past it.
    task automatic wait_out(output logic [7:0] d, output int t);
        int w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("out_valid_seen", out_valid, 1'b1);
        d = out_data;
        t = cyc;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [5];
        logic [7:0] d;
        logic [7:0] d1;
        int         t0;
        int         t1;
        int         p0;
        int         bad;
        logic [7:0] burst [5];

        tbl[0] = '{key: 8'h5A, pt: 8'h3C, ct: 8'h66};
        tbl[1] = '{key: 8'h0F, pt: 8'hFF, ct: 8'hF0};
        tbl[2] = '{key: 8'hA5, pt: 8'h5A, ct: 8'hFF};
        tbl[3] = '{key: 8'h80, pt: 8'h01, ct: 8'h81};
        tbl[4] = '{key: 8'h00, pt: 8'hC3, ct: 8'hC3};

        rst = 1'b1; key_we = 1'b0; key_in = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_c_start", c_start, 1'b0);
        check("rst_c_key", c_key, 8'h00);
        check("rst_c_plaintext", c_plaintext, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);

        // Single-byte transactions from the table
        for (int i = 0; i < 5; i++) begin
            p0 = pulses;
            keywr(tbl[i].key);
            push(tbl[i].pt);
            wait_cstart(t0);
            check("row_c_key", c_key, tbl[i].key);
            wait_out(d, t1);
            check("row_out_data", d, tbl[i].ct);
            check("row_latency", t1 - t0, CORE_LAT + 1);
            step(3);
            check("row_one_pulse", pulses - p0, 1);
            check("row_busy_idle", busy, 1'b0);
        end

        // Burst: hold the first result so the FIFO fills behind it
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'hA5; burst[3] = 8'h12; burst[4] = 8'h34;
        out_ready = 1'b0;
        keywr(8'h0F);
        push(burst[0]);
        wait_out(d, t1);
        check("burst_out0", d, burst[0] ^ ek(8'h0F, 0));
        for (int i = 1; i < 5; i++) begin
            check("burst_in_ready_before", in_ready, 1'b1);
            push(burst[i]);
        end
        check("burst_in_ready_full", in_ready, 1'b0);
        check("burst_busy", busy, 1'b1);
        out_ready = 1'b1;
        step(1);
        for (int i = 1; i < 5; i++) begin
            wait_out(d, t1);
            check("burst_out", d, burst[i] ^ ek(8'h0F, i));
        end

        // Backpressure: first result held for 50 cycles, no new issue meanwhile
        step(4);
        out_ready = 1'b0;
        keywr(8'h3C);
        push(8'h01);
        push(8'h02);
        wait_out(d1, t1);
        check("bp_out0", d1, 8'h01 ^ ek(8'h3C, 0));
        p0  = pulses;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!out_valid || out_data != d1 || c_start) bad++;
        end
        check("bp_hold_violations", bad, 0);
        check("bp_no_new_start", pulses - p0, 0);
        out_ready = 1'b1;
        step(1);
        wait_out(d, t1);
        check("bp_out1", d, 8'h02 ^ ek(8'h3C, 1));

        // Key change while a byte is in S_REQ
        step(4);
        keywr(8'h22);
        push(8'h44);
        push(8'h55);
        wait_cstart(t0);
        keywr(8'h11);
        check("kc_c_start_still", c_start, 1'b1);
        check("kc_key_stable", c_key, 8'h22);
        wait_out(d, t1);
        check("kc_out0", d, 8'h66);
        wait_out(d, t1);
        check("kc_out1", d, 8'h44);

        // Key roll (or constant key when the roll feature is off)
        step(4);
        keywr(8'h10);
        for (int i = 0; i < 3; i++) push(8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_out(d, t1);
            check("roll_out", d, ek(8'h10, i));
        end

        // Timeout with a stalled core
        step(4);
        core_stall = 1'b1;
        keywr(8'h01);
        push(8'h02);
        wait_cstart(t0);
        step(TMO);
        check("tmo_err_before", err, 1'b0);
        check("tmo_start_before", c_start, 1'b1);
        step(1);
        check("tmo_err_set", err, 1'b1);
        check("tmo_start_dropped", c_start, 1'b0);
        step(2);
        check("tmo_back_idle", busy, 1'b0);
        check("tmo_no_output", out_valid, 1'b0);
        core_stall = 1'b0;
        push(8'h0F);
        wait_out(d, t1);
        check("tmo_next_byte", d, 8'h0E);
        check("tmo_err_sticky", err, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("tmo_err_cleared", err, 1'b0);

        // Reset in the middle of a transaction
        step(2);
        keywr(8'h77);
        push(8'h10);
        wait_cstart(t0);
        push(8'h20);
        step(t0 + 4 - cyc);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_c_start", c_start, 1'b0);
        check("mrst_c_key", c_key, 8'h00);
        check("mrst_c_plaintext", c_plaintext, 8'h00);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, 8'h00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_err", err, 1'b0);
        step(3);
        push(8'h3C);
        wait_out(d, t1);
        check("mrst_fresh_byte", d, 8'h3C);
        step(4);
        check("mrst_final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
